// File: rtl/jtopl_seq.sv
// jtopl_seq: slot sequencer and register-write scheduler for the OPL core.
//
// Divides the external clock enable into the operator enable, walks the
// operator slots of a frame, raises the frame-start and sample strobes, and
// issues queued CPU register writes to the register bank at most once per
// operator cycle.
//
// Build option:
//   JTOPL_WRFIFO_EN  defined     -> DEPTH-entry write FIFO
//                    not defined -> single holding register (DEPTH ignored)
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   cen              external clock enable
//   din, addr, write CPU bus (addr 0 = index latch, 1 = data port)
//   busy             write queue full (registered)
//   lost             sticky: a data write was dropped
//   cenop            operator enable, one clk wide
//   slot             current operator slot
//   zero             frame-start pulse (cenop at slot 0)
//   sample           output-sample strobe, clk after the last-slot cenop
//   reg_we           register-bank write strobe
//   reg_addr/reg_din register-bank index/data, held between pops
module jtopl_seq #(
    parameter int DIV   = 4,
    parameter int SLOTS = 18,
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic [7:0] din,
    input  logic       addr,
    input  logic       write,
    output logic       busy,
    output logic       lost,
    output logic       cenop,
    output logic [4:0] slot,
    output logic       zero,
    output logic       sample,
    output logic       reg_we,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_din
);
    localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
    localparam logic [4:0]    SLOT_MAX = 5'(SLOTS - 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("jtopl_seq: DEPTH must be a power of two, at least 2");
    end

    logic [CW-1:0] cnt;
    logic [7:0]    idx;
    logic          push_req;
    logic          full;
    logic          pop;
    logic [15:0]   head;

    // rst_n is folded in so downstream logic never sees an enable during reset.
    assign cenop    = cen & (cnt == CNT_MAX) & rst_n;
    assign zero     = cenop & (slot == 5'd0);
    assign push_req = write & addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            slot   <= 5'd0;
            sample <= 1'b0;
        end else begin
            if (cen) begin
                cnt <= (cnt == CNT_MAX) ? '0 : cnt + CW'(1);
            end
            if (cenop) begin
                slot <= (slot == SLOT_MAX) ? 5'd0 : slot + 5'd1;
            end
            sample <= cenop & (slot == SLOT_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= 8'd0;
            lost     <= 1'b0;
            reg_we   <= 1'b0;
            reg_addr <= 8'd0;
            reg_din  <= 8'd0;
        end else begin
            if (write && !addr) begin
                idx <= din;
            end
            if (push_req && full) begin
                lost <= 1'b1;
            end
            reg_we <= pop;
            if (pop) begin
                {reg_addr, reg_din} <= head;
            end
        end
    end

`ifdef JTOPL_WRFIFO_EN
    localparam int AW = $clog2(DEPTH);

    logic [15:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;
    logic          push;

    // Pop looks at the registered occupancy, so an entry pushed into an
    // empty FIFO on a cenop edge waits for the following cenop.
    assign full = busy;
    assign pop  = cenop & (count != '0);
    assign push = push_req & ~full;
    assign head = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + (AW+1)'(1);
        end else if (pop && !push) begin
            count_nxt = count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {idx, din};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            busy   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            busy  <= (count_nxt == (AW+1)'(DEPTH));
        end
    end
`else
    logic        hold_vld;
    logic [15:0] hold;

    // A write arriving on the issuing cenop still sees the slot occupied
    // and is dropped.
    assign full = hold_vld;
    assign busy = hold_vld;
    assign pop  = cenop & hold_vld;
    assign head = hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_vld <= 1'b0;
            hold     <= 16'd0;
        end else if (pop) begin
            hold_vld <= 1'b0;
        end else if (push_req && !hold_vld) begin
            hold_vld <= 1'b1;
            hold     <= {idx, din};
        end
    end
`endif

endmodule

// File: tb/tb_jtopl_seq.sv
// Self-checking bench for jtopl_seq. A queue-based reference model tracks the
// cen count, index, write queue and strobes; directed tables and sequences
// cover the cadence, single write, overflow, push/pop overlap and reset cases.
module tb_jtopl_seq;
    localparam int DIV   = 4;
    localparam int SLOTS = 18;
    localparam int DEPTH = 4;
`ifdef JTOPL_WRFIFO_EN
    localparam int EFF = DEPTH;
`else
    localparam int EFF = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cen = 1'b0;
    logic [7:0] din = 8'd0;
    logic       addr = 1'b0;
    logic       write = 1'b0;
    logic       busy, lost, cenop, zero, sample, reg_we;
    logic [4:0] slot;
    logic [7:0] reg_addr, reg_din;

    jtopl_seq #(.DIV(DIV), .SLOTS(SLOTS), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .din(din), .addr(addr),
        .write(write), .busy(busy), .lost(lost), .cenop(cenop), .slot(slot),
        .zero(zero), .sample(sample), .reg_we(reg_we), .reg_addr(reg_addr),
        .reg_din(reg_din)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    int          m_cens;
    logic [7:0]  m_idx;
    logic [15:0] m_q[$];
    logic        m_lost, m_we, m_sample;
    logic [7:0]  m_raddr, m_rdin;

    int          n_cenop, n_zero, n_sample;
    logic [7:0]  we_log[$];
    logic        last_cenop;

    typedef struct {
        logic       c, w, a;
        logic [7:0] d;
        logic       e_cenop, e_we;
        logic [7:0] e_raddr, e_rdin;
        logic       e_busy, e_lost;
    } vec_t;
    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int m_slot();
        return (m_cens / DIV) % SLOTS;
    endfunction

    function automatic void model_reset();
        m_cens = 0; m_idx = 8'd0; m_q.delete();
        m_lost = 1'b0; m_we = 1'b0; m_sample = 1'b0;
        m_raddr = 8'd0; m_rdin = 8'd0;
    endfunction

    function automatic void clear_counts();
        n_cenop = 0; n_zero = 0; n_sample = 0; we_log.delete();
    endfunction

    task automatic step(input logic c, input logic w, input logic a, input logic [7:0] d);
        logic       cenop_e, pop, full_old;
        int         slot_old;
        @(negedge clk);
        cen = c; write = w; addr = a; din = d;
        #1;
        slot_old = m_slot();
        cenop_e  = c && ((m_cens % DIV) == DIV - 1);
        check("cenop", 32'(cenop), 32'(cenop_e));
        check("zero", 32'(zero), 32'(cenop_e && slot_old == 0));
        last_cenop = cenop;
        if (cenop) n_cenop++;
        if (zero) n_zero++;
        full_old = (m_q.size() == EFF);
        pop      = cenop_e && (m_q.size() != 0);
        m_we     = pop;
        m_sample = cenop_e && (slot_old == SLOTS - 1);
        if (pop) {m_raddr, m_rdin} = m_q.pop_front();
        if (w && !a) m_idx = d;
        else if (w && a) begin
            if (full_old) m_lost = 1'b1;
            else m_q.push_back({m_idx, d});
        end
        if (c) m_cens = (m_cens + 1) % (DIV * SLOTS);
        @(posedge clk);
        #1;
        check("slot", 32'(slot), 32'(m_slot()));
        check("busy", 32'(busy), 32'(m_q.size() == EFF));
        check("lost", 32'(lost), 32'(m_lost));
        check("sample", 32'(sample), 32'(m_sample));
        check("reg_we", 32'(reg_we), 32'(m_we));
        check("reg_addr", 32'(reg_addr), 32'(m_raddr));
        check("reg_din", 32'(reg_din), 32'(m_rdin));
        if (reg_we) we_log.push_back(reg_din);
        if (sample) n_sample++;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0; cen = 1'b1; write = 1'b0; addr = 1'b0; din = 8'd0;
        #1;
        check("rst_cenop", 32'(cenop), 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_slot", 32'(slot), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_lost", 32'(lost), 32'd0);
        check("rst_sample", 32'(sample), 32'd0);
        check("rst_reg_we", 32'(reg_we), 32'd0);
        check("rst_reg_addr", 32'(reg_addr), 32'd0);
        check("rst_reg_din", 32'(reg_din), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1; cen = 1'b0;
    endtask

    initial begin
        model_reset();
        clear_counts();

        // reset and frame cadence
        pulse_reset();
        clear_counts();
        for (int i = 0; i < 200; i++) step(1'b1, 1'b0, 1'b0, 8'd0);
        check("cadence_cenops", 32'(n_cenop), 32'd50);
        check("cadence_zeros", 32'(n_zero), 32'd3);
        check("cadence_samples", 32'(n_sample), 32'd2);

        // single write, table driven
        tbl[0] = '{1'b0, 1'b1, 1'b0, 8'h20, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 8'h00, 8'h00, (EFF == 1), 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, (EFF == 1), 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, (EFF == 1), 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, (EFF == 1), 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h20, 8'h55, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h20, 8'h55, 1'b0, 1'b0};
        pulse_reset();
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].c, tbl[i].w, tbl[i].a, tbl[i].d);
            check("tbl_cenop", 32'(last_cenop), 32'(tbl[i].e_cenop));
            check("tbl_reg_we", 32'(reg_we), 32'(tbl[i].e_we));
            check("tbl_reg_addr", 32'(reg_addr), 32'(tbl[i].e_raddr));
            check("tbl_reg_din", 32'(reg_din), 32'(tbl[i].e_rdin));
            check("tbl_busy", 32'(busy), 32'(tbl[i].e_busy));
            check("tbl_lost", 32'(lost), 32'(tbl[i].e_lost));
        end

        // burst and overflow
        pulse_reset();
        step(1'b0, 1'b1, 1'b0, 8'h30);
        for (int i = 1; i <= 6; i++) begin
            step(1'b0, 1'b1, 1'b1, 8'(i));
            check("burst_busy", 32'(busy), 32'(i >= EFF));
        end
        check("burst_lost", 32'(lost), 32'd1);
        clear_counts();
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 8'd0);
        check("burst_issued", 32'(we_log.size()), 32'(EFF));
        for (int i = 0; i < we_log.size(); i++) check("burst_order", 32'(we_log[i]), 32'(i + 1));

        // push and pop on the same clk
        pulse_reset();
        step(1'b0, 1'b1, 1'b0, 8'h40);
        step(1'b0, 1'b1, 1'b1, 8'hA1);
        step(1'b0, 1'b1, 1'b1, 8'hB2);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'd0);
        step(1'b1, 1'b1, 1'b1, 8'hC3);
        check("overlap_we", 32'(reg_we), 32'd1);
        check("overlap_head", 32'(reg_din), 32'hA1);
`ifdef JTOPL_WRFIFO_EN
        check("overlap_busy", 32'(busy), 32'd0);
        step(1'b0, 1'b1, 1'b1, 8'hD4);
        check("overlap_occ3", 32'(busy), 32'd0);
        step(1'b0, 1'b1, 1'b1, 8'hE5);
        check("overlap_occ4", 32'(busy), 32'd1);
        clear_counts();
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 8'd0);
        check("overlap_cnt", 32'(we_log.size()), 32'd4);
        if (we_log.size() == 4) begin
            check("overlap_o0", 32'(we_log[0]), 32'hB2);
            check("overlap_o1", 32'(we_log[1]), 32'hC3);
            check("overlap_o2", 32'(we_log[2]), 32'hD4);
            check("overlap_o3", 32'(we_log[3]), 32'hE5);
        end
`else
        check("overlap_lost", 32'(lost), 32'd1);
`endif

        // reset with entries queued at slot 9
        pulse_reset();
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, 8'(8'h10 + i));
        for (int i = 0; i < 36; i++) step(1'b1, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 8'(8'h90 + i));
        check("midrst_slot9", 32'(slot), 32'd9);
        check("midrst_lost_before", 32'(lost), 32'd1);
        pulse_reset();
        clear_counts();
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 8'd0);
        check("midrst_no_we", 32'(we_log.size()), 32'd0);
        check("midrst_slot", 32'(slot), 32'd5);

        // two data writes on consecutive clks
        pulse_reset();
        step(1'b0, 1'b1, 1'b1, 8'h11);
        step(1'b0, 1'b1, 1'b1, 8'h22);
        check("pair_lost", 32'(lost), 32'(EFF == 1));
        clear_counts();
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, 8'd0);
        check("pair_issued", 32'(we_log.size()), 32'(EFF == 1 ? 1 : 2));
        if (we_log.size() > 0) check("pair_first", 32'(we_log[0]), 32'h11);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if (i % 600 == 0) pulse_reset();
            step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 3),
                 1'($urandom_range(0, 1)), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/jtopl_seq.md
# jtopl_seq

Slot sequencer and register-write scheduler for the OPL core. It divides the external clock enable into the internal operator enable and walks the 18-slot operator frame. It generates the frame-start and sample strobes, and feeds the register bank. CPU writes are queued here and issued to the register bank at most once per operator cycle, so the bank never sees back-to-back bus writes.

## Interface
Parameters:
- `DIV`, 4: `cen` pulses per `cenop` pulse.
- `SLOTS`, 18: operator slots per frame.
- `DEPTH`, 4: write FIFO entries. Must be a power of two, at least 2.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cen` in 1: external clock enable.
- `din` in 8: CPU data.
- `addr` in 1: 0 selects the index latch, 1 selects the data port.
- `write` in 1: one-`clk` bus write strobe, already decoded from `cs_n`/`wr_n`.
- `busy` out 1: write FIFO is full.
- `lost` out 1: sticky flag; a data write was dropped.
- `cenop` out 1: internal operator enable, one `clk` wide.
- `slot` out 5: current slot, 0..`SLOTS`-1.
- `zero` out 1: frame-start pulse.
- `sample` out 1: output-sample strobe, one `clk` wide.
- `reg_we` out 1: register-bank write strobe, one `clk` wide.
- `reg_addr` out 8: register index for `reg_we`.
- `reg_din` out 8: register data for `reg_we`.

## Operation
- **Divider:** `cnt` counts 0..`DIV`-1, advancing on each `cen`.
  - `cenop` = `cen` & (`cnt`==`DIV`-1) & `rst_n`. It is combinational from registered state.
- **Slot counter:** advances on `cenop`; wraps from `SLOTS`-1 to 0.
- **Frame strobes:**
  - `zero` = `cenop` & (`slot`==0).
  - `sample` is registered and goes high in the `clk` after the `cenop` that moves `slot` from `SLOTS`-1 to 0.
- **Index latch:** a `write` with `addr`=0 latches `din` into an 8-bit index register.
  - This is always accepted, even when `busy` is high.
- **Data write:** a `write` with `addr`=1 pushes {index, `din`} into the FIFO.
  - If the FIFO is full, the entry is dropped and `lost` is set. `lost` clears only on reset.
- **Drain:** on a `cenop` with the FIFO non-empty, the head entry is popped into `reg_addr`/`reg_din`. `reg_we` is high for the next `clk`.
  - At most one pop per `cenop`.
  - `reg_addr`/`reg_din` hold their values until the next pop.
- **Simultaneous push and pop in one `clk`:**
  - Both take effect and the occupancy is unchanged.
  - The pop takes the old head.
  - A push into an empty FIFO on a `cenop` cycle is not popped until the following `cenop`.
- **Pointers:** write and read pointers are log2(`DEPTH`) bits and wrap naturally. A `DEPTH`+1-value occupancy counter decides full and empty.
- **Reset:** asserting `rst_n` mid-frame or with entries queued discards the FIFO and restarts the frame at slot 0 once released.

## Timing
- **Reset values:**
  - `cnt`=0, `slot`=0, index=0, FIFO empty.
  - `busy`=0, `lost`=0, `sample`=0, `reg_we`=0, `reg_addr`=0, `reg_din`=0.
  - `cenop`=0 and `zero`=0 while `rst_n` is low.
- **Frame period:** `DIV`×`SLOTS` `cen` pulses (72 with the defaults).
- **Write latency:** from a data `write` at edge t (FIFO empty), `reg_we` appears 1 `clk` after the first `cenop` at an edge after t.
  - Worst case with `cen`=1 is `DIV`+1 clks.
- **`busy` timing:** registered. It rises in the `clk` after the push that fills the FIFO and falls in the `clk` after the pop that frees an entry.
- **`cen` low:** the divider, slot counter and drain all freeze. Pushes are still accepted.

## Configuration
- `JTOPL_WRFIFO_EN` defined: a FIFO of `DEPTH` entries, as described above.
- Not defined: a single holding register, i.e. effective depth 1.
  - `busy` is high from the `clk` after a data write until the `clk` after its issuing `cenop`.
  - A data write while `busy` is high is dropped and sets `lost`.
  - `DEPTH` is ignored.

## Test plan
- **Reset and frame cadence:** reset, then `cen`=1 held for 200 clks. Required:
  - `cenop` every 4 clks.
  - `slot` runs 0..17 and wraps.
  - `zero` fires every 72 clks.
  - `sample` fires 1 clk after each 17→0 wrap.
- **Single write:** write index 0x20, then data 0x55. Required: exactly one `reg_we` with `reg_addr`=0x20, `reg_din`=0x55, 1 clk after the next `cenop`.
- **Burst and overflow:** 6 back-to-back data writes 0x01..0x06, FIFO enabled. Required:
  - `busy` rises after the 4th write.
  - 0x05 and 0x06 are dropped and `lost`=1.
  - `reg_we` issues 0x01..0x04 on 4 consecutive `cenop`s.
- **Simultaneous push and pop:** a data write on the same `clk` as a `cenop`, with 2 entries queued. Required: occupancy stays 2 and the order is preserved.
- **Reset mid-operation:** pulse `rst_n` low for 1 clk with 3 entries queued at `slot`=9. Required:
  - No further `reg_we`.
  - `slot` restarts at 0.
  - `busy`=0 and `lost`=0.
- **`JTOPL_WRFIFO_EN` undefined:** two data writes 1 clk apart. Required: the second is dropped and `lost`=1.
